// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: memory/IO responder for the Multi_CPU bus.
// Answers CPU requests (cpu_mio/mem_w/addr_in/wdata) with rdata and a one-cycle
// mio_ready pulse, decoding each request to a synchronous data RAM or to a small
// IO register file (LED, switches, reload timer). The timer drives the CPU INT line.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cpu_mio, mem_w     request valid / write select (held until mio_ready)
//   addr_in, wdata     byte address (word access), write data
//   rdata, mio_ready   read data, one-cycle completion pulse
//   ram_addr, ram_we,
//   ram_din, ram_dout  synchronous RAM port (ram_dout valid one cycle after address)
//   sw, led            switch inputs, LED register
//   int_out            registered timer interrupt
module mio_bus_ctrl #(
    parameter int unsigned RAM_AW         = 10,
    parameter logic [31:0] IO_BASE        = 32'hF000_0000,
    parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              mem_w,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic              int_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, DONE} state_t;

    state_t      state, state_next;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic [29:0] io_off;
    logic        is_ram, is_io;
    logic [1:0]  io_sel;
    logic [31:0] io_rdata;
    logic        io_wr, wr_led, wr_tmr, wr_ctrl;

    logic [31:0] tmr_val, tmr_reload;
    logic        tmr_en, tmr_ie, tmr_flag, tmr_wrap;

    // Byte-lane bits are not part of word addressing.
    logic        addr_unused;
    assign addr_unused = ^addr_in[1:0];

    // Decode from the latched word address.
    assign is_ram = (addr_q[31:RAM_AW+2] == '0);
    assign io_off = addr_q[31:2] - IO_BASE[31:2];
    assign is_io  = !is_ram && (io_off[29:2] == '0);
    assign io_sel = io_off[1:0];

    assign io_wr   = (state == ACCESS) && we_q && is_io;
    assign wr_led  = io_wr && (io_sel == 2'd0);
    assign wr_tmr  = io_wr && (io_sel == 2'd2);
    assign wr_ctrl = io_wr && (io_sel == 2'd3);

    assign tmr_wrap = tmr_en && (tmr_val == '0);

    always_comb begin
        io_rdata = UNMAPPED_RDATA;
        if (is_io) begin
            case (io_sel)
                2'd0:    io_rdata = {16'h0000, led};
                2'd1:    io_rdata = {16'h0000, sw};
                2'd2:    io_rdata = tmr_val;
                default: io_rdata = {28'h0000000, tmr_flag, 1'b0, tmr_ie, tmr_en};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        mio_ready  = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q[RAM_AW+1:2];
        ram_din    = wdata_q;
        case (state)
            IDLE:   if (cpu_mio) state_next = ACCESS;
            ACCESS: begin
                ram_we     = we_q && is_ram;
                state_next = (is_ram && !we_q) ? RDATA : DONE;
            end
            RDATA:  state_next = DONE;
            DONE: begin
                mio_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata   <= '0;
            led     <= '0;
        end else begin
            if (state == IDLE && cpu_mio) begin
                addr_q  <= addr_in[31:2];
                wdata_q <= wdata;
                we_q    <= mem_w;
            end
            if (state == ACCESS && !we_q && !is_ram) rdata <= io_rdata;
            if (state == RDATA)                      rdata <= ram_dout;
            if (wr_led)                              led   <= wdata_q[15:0];
        end
    end

    // Timer: a CPU write to the value register overrides counting; a wrap
    // sets the flag even when a write-1 clear lands on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_val    <= '0;
            tmr_reload <= '0;
            tmr_en     <= 1'b0;
            tmr_ie     <= 1'b0;
            tmr_flag   <= 1'b0;
            int_out    <= 1'b0;
        end else begin
            if (wr_tmr) begin
                tmr_val    <= wdata_q;
                tmr_reload <= wdata_q;
            end else if (tmr_wrap) begin
                tmr_val <= tmr_reload;
            end else if (tmr_en) begin
                tmr_val <= tmr_val - 32'd1;
            end
            if (wr_ctrl) begin
                tmr_en <= wdata_q[0];
                tmr_ie <= wdata_q[1];
            end
            if (tmr_wrap)                    tmr_flag <= 1'b1;
            else if (wr_ctrl && wdata_q[2])  tmr_flag <= 1'b0;
            int_out <= tmr_flag & tmr_ie;
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Testbench for mio_bus_ctrl: directed bus requests; expected read data and
// completion cycle are queued at issue and compared by an independent monitor.
module tb_mio_bus_ctrl;

    localparam int unsigned RAM_AW  = 10;
    localparam logic [31:0] IO_BASE = 32'hF000_0000;

    logic              clk, rst, cpu_mio, mem_w;
    logic [31:0]       addr_in, wdata, rdata, ram_din, ram_dout;
    logic              mio_ready, ram_we, int_out;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       sw, led;

    mio_bus_ctrl #(
        .RAM_AW(RAM_AW),
        .IO_BASE(IO_BASE),
        .UNMAPPED_RDATA(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .mem_w(mem_w),
        .addr_in(addr_in), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .sw(sw), .led(led), .int_out(int_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int unsigned       we_count = 0;
    logic [RAM_AW-1:0] we_addr  = '0;
    logic [31:0]       we_din   = '0;
    always @(negedge clk) begin
        if (ram_we) begin
            we_count <= we_count + 1;
            we_addr  <= ram_addr;
            we_din   <= ram_din;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rd  = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completion pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && mio_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_ready actual=1 required=0 cycle=%0d", cyc);
            end else begin
                e = sb.pop_front();
                check32("rdata", rdata, e.rdata);
                check32("ready_cycle", cyc, e.cyc);
            end
        end
    end

    // cont: request follows a kept-high cpu_mio (issued in the DONE cycle).
    // keep: leave cpu_mio high after completion.
    task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input int unsigned lat,
                             input bit cont, input bit keep);
        exp_t e;
        bit   seen;
        if (!cont) @(negedge clk);
        if (!we) last_rd = exp_rd;
        e.rdata = last_rd;
        e.cyc   = cyc + (cont ? 2 : 1) + lat;
        sb.push_back(e);
        mem_w   = we;
        addr_in = a;
        wdata   = d;
        cpu_mio = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mio_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout addr=0x%08h actual=no_ready required=ready", a);
        end
        if (!keep) cpu_mio = 1'b0;
    endtask

    int unsigned w0;

    initial begin
        rst = 1'b0; cpu_mio = 1'b0; mem_w = 1'b0; addr_in = '0; wdata = '0; sw = 16'h00FF;
        repeat (3) @(negedge clk);
        check32("rst_rdata", rdata, 32'h0);
        check32("rst_ready", {31'h0, mio_ready}, 32'h0);
        check32("rst_led", {16'h0, led}, 32'h0);
        check32("rst_int", {31'h0, int_out}, 32'h0);
        check32("rst_ram_we", {31'h0, ram_we}, 32'h0);
        rst = 1'b1;

        // RAM write then read
        do_access(1'b1, 32'h0000_0010, 32'h1234_5678, '0, 1, 0, 0);
        check32("ram_we_count", we_count, 32'd1);
        check32("ram_we_addr", {22'h0, we_addr}, 32'd4);
        check32("ram_we_din", we_din, 32'h1234_5678);
        do_access(1'b0, 32'h0000_0010, '0, 32'h1234_5678, 2, 0, 0);
        check32("ram_rd_no_we", we_count, 32'd1);

        // IO registers
        do_access(1'b1, IO_BASE, 32'h0000_A5A5, '0, 1, 0, 0);
        check32("led", {16'h0, led}, 32'h0000_A5A5);
        do_access(1'b0, IO_BASE + 32'h4, '0, 32'h0000_00FF, 1, 0, 0);
        do_access(1'b0, IO_BASE, '0, 32'h0000_A5A5, 1, 0, 0);

        // Unmapped
        w0 = we_count;
        do_access(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1, 0, 0);
        do_access(1'b1, IO_BASE + 32'h10, 32'h0000_1234, '0, 1, 0, 0);
        check32("unmapped_no_we", we_count, w0);
        check32("unmapped_led", {16'h0, led}, 32'h0000_A5A5);
        do_access(1'b0, 32'h8000_0000, '0, 32'h0, 1, 0, 0);

        // Timer: reload 3, enable with int_en; E = edge committing the ctrl write.
        do_access(1'b1, IO_BASE + 32'h8, 32'd3, '0, 1, 0, 0);
        do_access(1'b1, IO_BASE + 32'hC, 32'h3, '0, 1, 0, 0);   // t=0 after E
        repeat (4) @(negedge clk);                                  // flag set at E+4
        check32("int_before", {31'h0, int_out}, 32'h0);
        @(negedge clk);
        check32("int_after_wrap", {31'h0, int_out}, 32'h1);
        do_access(1'b0, IO_BASE + 32'h8, '0, 32'd0, 1, 0, 0);     // samples value after E+7
        do_access(1'b0, IO_BASE + 32'hC, '0, 32'hB, 1, 0, 0);
        do_access(1'b1, IO_BASE + 32'hC, 32'h7, '0, 1, 0, 0);     // clear at E+14
        @(negedge clk);
        check32("int_cleared", {31'h0, int_out}, 32'h0);
        repeat (3) @(negedge clk);
        do_access(1'b1, IO_BASE + 32'hC, 32'h7, '0, 1, 0, 1);     // clear at E+21
        do_access(1'b1, IO_BASE + 32'hC, 32'h7, '0, 1, 1, 0);     // clear on wrap E+24
        check32("int_pre_set_wins", {31'h0, int_out}, 32'h0);
        do_access(1'b0, IO_BASE + 32'hC, '0, 32'hB, 1, 0, 0);

        // Back-to-back writes with cpu_mio held high
        w0 = we_count;
        do_access(1'b1, 32'h0000_0020, 32'hCAFE_BABE, '0, 1, 0, 1);
        do_access(1'b1, 32'h0000_0024, 32'h0BAD_F00D, '0, 1, 1, 0);
        check32("b2b_we_count", we_count, w0 + 2);
        check32("b2b_we_addr", {22'h0, we_addr}, 32'd9);
        do_access(1'b0, 32'h0000_0020, '0, 32'hCAFE_BABE, 2, 0, 0);
        do_access(1'b0, 32'h0000_0024, '0, 32'h0BAD_F00D, 2, 0, 0);
        do_access(1'b1, 32'h0000_0028, 32'h1111_1111, '0, 1, 0, 0);

        // Reset aborting an in-flight RAM read, then an in-flight RAM write
        @(negedge clk);
        mem_w = 1'b0; addr_in = 32'h0000_0010; cpu_mio = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_mio = 1'b0;
        #1;
        check32("abort_ready", {31'h0, mio_ready}, 32'h0);
        check32("abort_rdata", rdata, 32'h0);
        check32("abort_led", {16'h0, led}, 32'h0);
        check32("abort_int", {31'h0, int_out}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_rd = '0;
        repeat (6) @(negedge clk);
        mem_w = 1'b1; addr_in = 32'h0000_0028; wdata = 32'hAAAA_AAAA; cpu_mio = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_mio = 1'b0; mem_w = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        do_access(1'b0, 32'h0000_0028, '0, 32'h1111_1111, 2, 0, 0);
        do_access(1'b0, IO_BASE + 32'hC, '0, 32'h0, 1, 0, 0);
        do_access(1'b0, IO_BASE + 32'h8, '0, 32'h0, 1, 0, 0);
        do_access(1'b0, 32'h0000_0010, '0, 32'h1234_5678, 2, 0, 0);
        check32("post_rst_int", {31'h0, int_out}, 32'h0);
        check32("post_rst_led", {16'h0, led}, 32'h0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check32("sb_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Memory/IO responder on the far end of the Multi_CPU bus: it answers the CPU's CPU_MIO / mem_w / Addr_out / Data_out requests with Data_in and a one-cycle MIO_ready pulse.
It decodes each request to the synchronous data RAM or to a small IO register file (LEDs, switches, reload timer).
It also drives the CPU's INT input from the timer.

Parameters:
RAM_AW, 10, RAM word-address width; RAM region is byte addresses 0 .. 4*2^RAM_AW-1.
IO_BASE, 32'hF000_0000, base byte address of IO registers.
UNMAPPED_RDATA, 32'h0000_0000, read data returned for unmapped addresses.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
cpu_mio  in  1  CPU request valid; held with addr/data/we stable until mio_ready.
mem_w  in  1  1 = write, 0 = read; sampled with cpu_mio.
addr_in  in  32  byte address; bits [1:0] ignored (word access only).
wdata  in  32  CPU write data.
rdata  out  32  read data to CPU (CPU Data_in).
mio_ready  out  1  one-cycle completion pulse (CPU MIO_ready).
ram_addr  out  RAM_AW  RAM word address.
ram_we  out  1  RAM write enable.
ram_din  out  32  RAM write data.
ram_dout  in  32  RAM read data, registered (valid one cycle after address).
sw  in  16  switch inputs.
led  out  16  LED register.
int_out  out  1  timer interrupt to CPU INT.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE; rdata=0, mio_ready=0, ram_we=0, ram_addr=0, ram_din=0, led=0, int_out=0.
  - Timer value, reload and ctrl registers = 0.
  - An in-flight request is aborted: no mio_ready and no write commit.
- Address decode on the latched address:
  - RAM if addr < 4*2^RAM_AW; word index is addr[RAM_AW+1:2].
  - IO at IO_BASE + 0x0: LED (R/W, low 16 bits).
  - IO_BASE + 0x4: switches (read-only, zero-extended; writes ignored).
  - IO_BASE + 0x8: timer; write sets both reload and value, read returns current value.
  - IO_BASE + 0xC: timer ctrl. bit0 enable, bit1 int_en, bit2 write-1 clears flag (reads 0). bit3 is the read-only flag.
  - Anything else: reads return UNMAPPED_RDATA, writes are dropped, the access still completes.
- FSM states: IDLE, ACCESS, RDATA, DONE.
  - IDLE: when cpu_mio=1, latch addr/wdata/mem_w and go to ACCESS.
  - ACCESS: drive ram_addr from the latch. ram_we=1 only for a RAM write, ram_din = latched wdata.
    - IO writes commit at the edge that leaves ACCESS.
    - RAM read goes to RDATA; every other access goes to DONE with rdata loaded (IO/unmapped read value, or unchanged for writes).
  - RDATA: capture ram_dout into rdata, go to DONE.
  - DONE: mio_ready=1 for exactly this cycle, rdata valid. cpu_mio is ignored. Next state IDLE.
- Latency (edge 0 = edge that samples cpu_mio in IDLE):
  - Writes, IO reads and unmapped accesses: mio_ready high in the cycle after edge 1.
  - RAM reads: mio_ready high in the cycle after edge 2.
  - Minimum request spacing is 3 cycles (writes/IO) or 4 cycles (RAM reads).
- A cpu_mio still high in the cycle after DONE is taken as a new request.
- rdata holds its value until the next read completes.
- Timer (32-bit down counter, runs every cycle while enable=1):
  - value==0 with enable=1 at an edge: value <= reload, flag <= 1.
  - Otherwise, if enabled: value <= value-1.
  - int_out = flag & int_en, registered.
- Simultaneous events:
  - CPU write to timer and decrement in the same edge: CPU write wins.
  - Flag set and write-1 clear in the same edge: set wins.
  - reload=0 with enable=1: flag is set every cycle.

Test Plan:
- Reset: hold rst=0 mid-RAM-read, release -> mio_ready never pulses for it; led=0, int_out=0, rdata=0.
- RAM write/read: write 0x12345678 to 0x0000_0010, then read 0x0000_0010 -> ram_we=1 one cycle with ram_addr=4. Read mio_ready exactly 2 edges after sampling, rdata=0x12345678. Write ready after 1 edge.
- IO: write 0x0000_A5A5 to IO_BASE+0 -> led=0xA5A5. With sw=0x00FF, read IO_BASE+4 -> rdata=0x000000FF, ready after 1 edge.
- Unmapped: read 0x8000_0000 -> rdata=UNMAPPED_RDATA, single mio_ready. Write to the same address -> no ram_we, no register change.
- Timer: write 3 to IO_BASE+8, write 0x3 to ctrl -> value counts 3,2,1,0, flag and int_out=1, reload to 3. Write 0x7 to ctrl -> flag clears. Force clear on the wrap edge -> flag stays 1.
- Back-to-back: keep cpu_mio high across two writes -> two distinct mio_ready pulses, 3 cycles apart, both commits visible.
